// File: rtl/rv_fanout_router_if.sv
// rtl/rv_fanout_router_if.sv - handshake bundle between one producer and the fan-out router
// Ports (signals):
//   in_vld/in_rdy/in_data/in_dest/in_bcast : producer-side ready/valid channel
//   out_vld/out_rdy/out_data               : NUM_OUT consumer channels, channel i at [i*DATA_W +: DATA_W]
//   err_dest/err_cnt                       : invalid-destination pulse and saturating count
// Modports: slave = router side, master = producer/consumer side.
interface rv_fanout_router_if #(
  parameter int NUM_OUT = 2,
  parameter int DATA_W  = 32
);
  localparam int DEST_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic                      in_vld;
  logic                      in_rdy;
  logic [DATA_W-1:0]         in_data;
  logic [DEST_W-1:0]         in_dest;
  logic                      in_bcast;
  logic [NUM_OUT-1:0]        out_vld;
  logic [NUM_OUT-1:0]        out_rdy;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic                      err_dest;
  logic [15:0]               err_cnt;

  modport slave (
    input  in_vld, in_data, in_dest, in_bcast, out_rdy,
    output in_rdy, out_vld, out_data, err_dest, err_cnt
  );

  modport master (
    output in_vld, in_data, in_dest, in_bcast, out_rdy,
    input  in_rdy, out_vld, out_data, err_dest, err_cnt
  );
endinterface

// File: rtl/rv_fanout_router.sv
// rtl/rv_fanout_router.sv - ready/valid fan-out router with one FIFO per output
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rv_fanout_router_if.slave (input channel, NUM_OUT output channels, error status)
// Unicast goes to FIFO[in_dest], broadcast goes atomically to every FIFO, and an
// out-of-range in_dest is accepted, dropped and counted.
module rv_fanout_router #(
  parameter int NUM_OUT = 2,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4
) (
  input logic                clk,
  input logic                rst_n,
  rv_fanout_router_if.slave  bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int DEST_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [DEST_W:0] NUM_OUT_W = (DEST_W + 1)'(NUM_OUT);

  // Pointers carry one extra bit: equal = empty, differ only in MSB = full.
  logic [AW:0]       wr_ptr [NUM_OUT];
  logic [AW:0]       rd_ptr [NUM_OUT];
  logic [DATA_W-1:0] mem    [NUM_OUT][DEPTH];

  logic [NUM_OUT-1:0]        full, empty, push, pop;
  logic [NUM_OUT*DATA_W-1:0] data_vec;
  logic                      dest_ok, sel_full, rdy, accept;
  logic                      err_dest_q;
  logic [15:0]               err_cnt_q;

  always_comb begin
    dest_ok  = {1'b0, bus.in_dest} < NUM_OUT_W;
    sel_full = 1'b0;
    full     = '0;
    empty    = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      full[i]  = (wr_ptr[i] ^ rd_ptr[i]) == {1'b1, {AW{1'b0}}};
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      if ({1'b0, bus.in_dest} == (DEST_W + 1)'(i)) sel_full = full[i];
    end
  end

  // Ready never looks at in_vld or out_rdy; a full FIFO refuses even if it is popped this cycle.
  always_comb begin
    if (!rst_n)            rdy = 1'b0;
    else if (bus.in_bcast) rdy = ~|full;
    else if (dest_ok)      rdy = !sel_full;
    else                   rdy = 1'b1;
  end

  assign accept = bus.in_vld && rdy;

  always_comb begin
    push     = '0;
    pop      = '0;
    data_vec = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      push[i] = accept && (bus.in_bcast ||
                (dest_ok && ({1'b0, bus.in_dest} == (DEST_W + 1)'(i))));
      pop[i]  = !empty[i] && bus.out_rdy[i];
      data_vec[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + (AW + 1)'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + (AW + 1)'(1);
      end
    end
  end

  // Storage is left out of reset; stale entries are unreachable once pointers are cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_dest_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      err_dest_q <= accept && !bus.in_bcast && !dest_ok;
      if (accept && !bus.in_bcast && !dest_ok && (err_cnt_q != 16'hFFFF))
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.in_rdy   = rdy;
  assign bus.out_vld  = ~empty;
  assign bus.out_data = data_vec;
  assign bus.err_dest = err_dest_q;
  assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_rv_fanout_router.sv
// tb/tb_rv_fanout_router.sv - scoreboard bench for rv_fanout_router (2- and 3-output instances)
module tb_rv_fanout_router;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_fanout_router_if #(.NUM_OUT(2), .DATA_W(32)) b2();
  rv_fanout_router_if #(.NUM_OUT(3), .DATA_W(32)) b3();

  rv_fanout_router #(.NUM_OUT(2), .DATA_W(32), .DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));
  rv_fanout_router #(.NUM_OUT(3), .DATA_W(32), .DEPTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.slave));

  typedef struct {
    logic [31:0] d;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t qe[$];
  exp_t e0, e1, ee;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   lat_check = 1'b0;
  int   err_model = 0;
  int   w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Output monitor for the 2-channel instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b2.out_vld[0]) begin
        if (q0.size() == 0) flag("ch0 spurious out_vld");
        else if (b2.out_rdy[0]) begin
          e0 = q0.pop_front();
          chk("ch0 data", b2.out_data[31:0], e0.d);
          if (lat_check) chk("ch0 latency", cyc, e0.acc + 1);
        end
      end
      if (b2.out_vld[1]) begin
        if (q1.size() == 0) flag("ch1 spurious out_vld");
        else if (b2.out_rdy[1]) begin
          e1 = q1.pop_front();
          chk("ch1 data", b2.out_data[63:32], e1.d);
          if (lat_check) chk("ch1 latency", cyc, e1.acc + 1);
        end
      end
    end
  end

  // Error monitor for the 3-channel instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b3.out_vld != 3'b000) flag("dut3 spurious out_vld");
      if (b3.err_dest) begin
        if (qe.size() == 0) flag("dut3 spurious err_dest");
        else begin
          ee = qe.pop_front();
          chk("err_dest timing", cyc, ee.acc + 1);
          chk("err_cnt", {16'h0, b3.err_cnt}, ee.d);
        end
      end
    end
  end

  task automatic send2(input logic [31:0] d, input logic dest, input logic bc, output int waited);
    bit ok;
    b2.in_vld = 1'b1; b2.in_data = d; b2.in_dest = dest; b2.in_bcast = bc;
    waited = 0; ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      if (b2.in_rdy) ok = 1'b1;
      else begin
        waited++;
        if (waited > 200) break;
      end
    end
    if (!ok) flag("send2 in_rdy timeout");
    else begin
      if (bc || dest == 1'b0) q0.push_back('{d, cyc});
      if (bc || dest == 1'b1) q1.push_back('{d, cyc});
    end
    @(posedge clk); #1;
    b2.in_vld = 1'b0;
  endtask

  task automatic send3(input logic [31:0] d, input logic [1:0] dest, output int waited);
    bit ok;
    b3.in_vld = 1'b1; b3.in_data = d; b3.in_dest = dest; b3.in_bcast = 1'b0;
    waited = 0; ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      if (b3.in_rdy) ok = 1'b1;
      else begin
        waited++;
        if (waited > 200) break;
      end
    end
    if (!ok) flag("send3 in_rdy timeout");
    else if (dest == 2'd3) begin
      if (err_model < 65535) err_model++;
      qe.push_back('{32'(err_model), cyc});
    end
    @(posedge clk); #1;
    b3.in_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q0.size() != 0 || q1.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        flag("drain timeout");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    b2.in_vld = 0; b2.in_data = 0; b2.in_dest = 0; b2.in_bcast = 0; b2.out_rdy = 0;
    b3.in_vld = 0; b3.in_data = 0; b3.in_dest = 0; b3.in_bcast = 0; b3.out_rdy = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_rdy", {31'h0, b2.in_rdy}, 32'h0);
    chk("reset out_vld", {30'h0, b2.out_vld}, 32'h0);
    chk("reset err_dest", {31'h0, b2.err_dest}, 32'h0);
    chk("reset err_cnt", {16'h0, b2.err_cnt}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_rdy", {31'h0, b2.in_rdy}, 32'h1);
    @(posedge clk); #1;

    // Unicast fill of FIFO1, then overflow attempt
    for (int i = 0; i < 4; i++) send2(32'hA0 + 32'(i), 1'b1, 1'b0, w);
    b2.in_vld = 1'b1; b2.in_data = 32'hA4; b2.in_dest = 1'b1; b2.in_bcast = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("full in_rdy", {31'h0, b2.in_rdy}, 32'h0);
      chk("fill out_vld", {30'h0, b2.out_vld}, 32'h2);
    end
    @(posedge clk); #1;
    b2.out_rdy = 2'b10;
    send2(32'hA4, 1'b1, 1'b0, w);
    drain();
    b2.out_rdy = 2'b00;

    // Broadcast blocked by a full FIFO0
    for (int i = 0; i < 4; i++) send2(32'hB0 + 32'(i), 1'b0, 1'b0, w);
    b2.in_vld = 1'b1; b2.in_data = 32'h55; b2.in_dest = 1'b0; b2.in_bcast = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("bcast blocked in_rdy", {31'h0, b2.in_rdy}, 32'h0);
      chk("bcast blocked out_vld", {30'h0, b2.out_vld}, 32'h1);
    end
    @(posedge clk); #1;
    b2.out_rdy = 2'b01;
    @(posedge clk); #1;
    b2.out_rdy = 2'b00;
    send2(32'h55, 1'b0, 1'b1, w);
    @(negedge clk);
    chk("bcast both out_vld", {30'h0, b2.out_vld}, 32'h3);
    @(posedge clk); #1;
    b2.out_rdy = 2'b11;
    drain();
    b2.out_rdy = 2'b00;

    // Streaming across pointer wrap
    b2.out_rdy = 2'b01;
    lat_check = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send2(32'(i), 1'b0, 1'b0, w);
      chk("stream no bubble", 32'(w), 32'h0);
    end
    drain();
    lat_check = 1'b0;
    b2.out_rdy = 2'b00;

    // Reset in the middle of a cycle with data buffered
    send2(32'hC0, 1'b0, 1'b0, w);
    send2(32'hC1, 1'b1, 1'b0, w);
    send2(32'hC2, 1'b0, 1'b1, w);
    b2.in_vld = 1'b1; b2.in_data = 32'hC3; b2.in_dest = 1'b0; b2.in_bcast = 1'b0;
    #2;
    rst_n = 1'b0;
    q0.delete(); q1.delete(); qe.delete(); err_model = 0;
    #1;
    chk("midreset out_vld", {30'h0, b2.out_vld}, 32'h0);
    chk("midreset in_rdy", {31'h0, b2.in_rdy}, 32'h0);
    b2.in_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    b2.out_rdy = 2'b11;
    repeat (8) @(negedge clk);
    chk("after reset out_vld", {30'h0, b2.out_vld}, 32'h0);
    chk("after reset err_cnt", {16'h0, b2.err_cnt}, 32'h0);
    @(posedge clk); #1;
    b2.out_rdy = 2'b00;

    // Invalid destination on the 3-output instance
    send3(32'h77, 2'd3, w);
    chk("invalid accepted at once", 32'(w), 32'h0);
    repeat (2) @(negedge clk);
    chk("err_dest one cycle", {31'h0, b3.err_dest}, 32'h0);
    chk("err_cnt after one", {16'h0, b3.err_cnt}, 32'h1);
    @(posedge clk); #1;
    for (int i = 1; i < 65535; i++) send3(32'(i), 2'd3, w);
    send3(32'h78, 2'd3, w);
    repeat (3) @(negedge clk);
    chk("err_cnt saturated", {16'h0, b3.err_cnt}, 32'hFFFF);
    chk("err_dest idle", {31'h0, b3.err_dest}, 32'h0);
    chk("err queue empty", 32'(qe.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv_fanout_router.md
# rv_fanout_router

Parametrised ready/valid fan-out router: one ready/valid source is steered to one of NUM_OUT ready/valid sinks by a destination field, or broadcast to all sinks, through an independent FIFO per output. It generalises the fixed point-to-point channel wiring in hierInclude tops, such as a producer block feeding two consumer blocks over separate rdy_vld channels. The block allows one producer to feed a parametrised set of consumers with buffering. It decouples back-pressure between consumers and counts misrouted transfers.

## Interface
- NUM_OUT, 2, number of output channels, legal range 2..8.
- DATA_W, 32, payload width in bits.
- DEPTH, 4, entries per output FIFO, power of two, ≥2.
- DEST_W, $clog2(NUM_OUT), derived, not overridable.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_vld  in  1  input valid.
- in_rdy  out  1  input ready.
- in_data  in  DATA_W  input payload.
- in_dest  in  DEST_W  target output index.
- in_bcast  in  1  1 = deliver to all outputs; in_dest ignored.
- out_vld  out  NUM_OUT  per-output valid.
- out_rdy  in  NUM_OUT  per-output ready.
- out_data  out  NUM_OUT*DATA_W  per-output payload; channel i occupies bits [i*DATA_W +: DATA_W].
- err_dest  out  1  one-cycle pulse when a transfer with invalid in_dest is accepted.
- err_cnt  out  16  saturating count of invalid-dest transfers.

## Operation
- Transfers:
  - An input transfer occurs on a cycle where in_vld && in_rdy.
  - An output transfer on channel i occurs on a cycle where out_vld[i] && out_rdy[i].
- Source rules:
  - Once in_vld is asserted, in_data, in_dest and in_bcast hold stable until the transfer.
  - in_vld does not deassert without a transfer.
- in_rdy:
  - Combinational from FIFO full flags, in_dest and in_bcast.
  - in_rdy does not depend on in_vld or on out_rdy.
- Unicast (in_bcast=0, in_dest<NUM_OUT): in_rdy = !full[in_dest]. The payload is pushed to FIFO[in_dest] only.
- Broadcast (in_bcast=1):
  - in_rdy = AND of !full[i] over all i.
  - The payload is pushed to all FIFOs in the same cycle (atomic).
  - Broadcast never partially delivers.
- Invalid destination (in_bcast=0, in_dest≥NUM_OUT; possible only when NUM_OUT is not a power of two):
  - in_rdy=1 and the payload is discarded.
  - err_dest pulses the cycle after the transfer.
  - err_cnt increments, saturating at 0xFFFF.
- Each output FIFO:
  - Circular buffer with DEPTH entries and rd/wr pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Pointers wrap naturally.
  - out_vld[i] = !empty[i].
  - out_data for channel i = head entry, driven from registers.
- Push and pop on the same FIFO in the same cycle:
  - Allowed when not full; occupancy is unchanged.
  - When full, in_rdy is already low (no pass-through while full), so only the pop occurs.
- Ordering: strict FIFO order per output. Outputs are mutually independent; a stalled output blocks only transfers that target it, including broadcasts.
- Reset (async, any time): all FIFOs empty, pointers 0, discarding in-flight contents. Outputs:
  - out_vld=0.
  - err_dest=0, err_cnt=0.
  - in_rdy=0 while rst_n=0.
  - FIFO storage contents are don't-care.

## Timing
- Latency: a payload accepted at cycle t appears on out_vld/out_data at cycle t+1 (no combinational input-to-output path).
- Throughput:
  - One transfer per cycle into any non-full output.
  - Sustained one per cycle per output when out_rdy is held high.
- in_rdy and the full flags update the cycle after a push or pop.
- err_dest is registered: high for exactly one cycle at t+1 per invalid transfer.
- err_cnt is valid at t+1.
- First cycle after rst_n deasserts: in_rdy may be 1 and all FIFOs accept.

## Test plan
- Unicast fill (NUM_OUT=2, DEPTH=4):
  - Stimulus: out_rdy=00, push 0xA0..0xA3 to dest 1, then offer 0xA4.
  - Required: in_rdy=0 while 0xA4 is offered.
  - Then raise out_rdy[1]: out_data[1] yields A0,A1,A2,A3,A4 in order, one per cycle; out_vld[0] stays 0.
- Broadcast blocking:
  - Stimulus: FIFO0 full, FIFO1 empty, offer bcast 0x55.
  - Required: in_rdy=0 and FIFO1 unchanged. After one pop from FIFO0, the broadcast is accepted and 0x55 reaches both outputs.
- Invalid dest (NUM_OUT=3):
  - Stimulus: send dest=3, payload 0x77.
  - Required: accepted with in_rdy=1, no out_vld asserted, err_dest pulses 1 cycle, err_cnt=1.
  - Preload err_cnt to 0xFFFF via 65535 errors, send one more: err_cnt stays 0xFFFF.
- Streaming with wrap:
  - Stimulus: 20 back-to-back unicasts to dest 0 with out_rdy[0]=1.
  - Required: 1-cycle latency per item, no bubbles, data 0..19 in order across pointer wrap.
- Reset mid-operation:
  - Stimulus: with FIFOs partially filled, pulse rst_n low mid-cycle.
  - Required: out_vld=0 and in_rdy=0 immediately. After release, old data never reappears and err_cnt=0.
